// File: rtl/selecionar_menor_ativo_pkg.sv
// Shared types and elaboration-time helpers for the active-node minimum finder.
// Sizing functions are evaluated only at elaboration to derive widths and beat counts.
package selecionar_menor_ativo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Index width never drops below one bit, even for a single node.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int pow2_ceil(input int n);
    int p;
    p = 1;
    while (p < n) p = p * 2;
    return p;
  endfunction

endpackage

// File: rtl/selecionar_menor_ativo_arvore_menor.sv
// Combinational min-reduction tree over LANES (valid, value, index) triples.
// The left child wins ties, so the lowest lane, and therefore the lowest node index, is kept.
module arvore_menor
  import selecionar_menor_ativo_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int CRITERIO_WIDTH = 5,
  parameter int IDX_WIDTH      = 3
) (
  input  logic [LANES-1:0]                valido,
  input  logic [LANES*CRITERIO_WIDTH-1:0] valor,
  input  logic [LANES*IDX_WIDTH-1:0]      indice,
  output logic [CRITERIO_WIDTH-1:0]       min_valor,
  output logic [IDX_WIDTH-1:0]            min_indice,
  output logic                            algum_valido
);

  localparam int FOLHAS = pow2_ceil(LANES);

  // Heap layout: node i has children 2i and 2i+1; leaves live at FOLHAS..2*FOLHAS-1.
  logic                      no_valido [2*FOLHAS];
  logic [CRITERIO_WIDTH-1:0] no_valor  [2*FOLHAS];
  logic [IDX_WIDTH-1:0]      no_indice [2*FOLHAS];

  always_comb begin
    for (int i = 0; i < 2*FOLHAS; i++) begin
      no_valido[i] = 1'b0;
      no_valor[i]  = '0;
      no_indice[i] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      no_valido[FOLHAS+l] = valido[l];
      no_valor[FOLHAS+l]  = valor[l*CRITERIO_WIDTH +: CRITERIO_WIDTH];
      no_indice[FOLHAS+l] = indice[l*IDX_WIDTH +: IDX_WIDTH];
    end
    for (int i = FOLHAS-1; i >= 1; i--) begin
      if (no_valido[2*i] && (!no_valido[2*i+1] || no_valor[2*i] <= no_valor[2*i+1])) begin
        no_valido[i] = 1'b1;
        no_valor[i]  = no_valor[2*i];
        no_indice[i] = no_indice[2*i];
      end else begin
        no_valido[i] = no_valido[2*i+1];
        no_valor[i]  = no_valor[2*i+1];
        no_indice[i] = no_indice[2*i+1];
      end
    end
  end

  assign min_valor    = no_valor[1];
  assign min_indice   = no_indice[1];
  assign algum_valido = no_valido[1];

endmodule

// File: rtl/selecionar_menor_ativo.sv
// Finds the minimum criterio among active nodes of a snapshot, LANES nodes per cycle,
// and publishes value, index and an empty flag once the last beat has been compared.
module selecionar_menor_ativo
  import selecionar_menor_ativo_pkg::*;
#(
  parameter  int NUM_NA         = 8,
  parameter  int CRITERIO_WIDTH = 5,
  parameter  int LANES          = 4,
  localparam int IDX_WIDTH      = clog2_min1(NUM_NA)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  output logic                             ocupado_o,
  output logic                             pronto_o,
  output logic [CRITERIO_WIDTH-1:0]        criterio_o,
  output logic [IDX_WIDTH-1:0]             indice_o,
  output logic                             vazio_o
);

  localparam int BEATS      = ceil_div(NUM_NA, LANES);
  localparam int BEAT_WIDTH = IDX_WIDTH + 1;
  localparam int PAD        = BEATS * LANES;
  localparam int LANE_BITS  = LANES * CRITERIO_WIDTH;
  localparam logic [BEAT_WIDTH-1:0]     LAST_BEAT    = BEAT_WIDTH'(BEATS - 1);
  localparam logic [CRITERIO_WIDTH-1:0] CRITERIO_MAX = '1;

  estado_t estado, estado_prox;

  logic [BEAT_WIDTH-1:0]            beat;
  logic [NUM_NA-1:0]                snap_ativo;
  logic [NUM_NA*CRITERIO_WIDTH-1:0] snap_criterio;
  logic [CRITERIO_WIDTH-1:0]        run_min;
  logic [IDX_WIDTH-1:0]             run_idx;
  logic                             found;

  logic [PAD-1:0]                pad_ativo;
  logic [PAD*CRITERIO_WIDTH-1:0] pad_criterio;
  int                            base;
  logic [LANES-1:0]              lane_valido;
  logic [LANE_BITS-1:0]          lane_valor;
  logic [LANES*IDX_WIDTH-1:0]    lane_indice;

  logic [CRITERIO_WIDTH-1:0] arv_valor;
  logic [IDX_WIDTH-1:0]      arv_indice;
  logic                      arv_valido;

  logic                      toma;
  logic [CRITERIO_WIDTH-1:0] prox_min;
  logic [IDX_WIDTH-1:0]      prox_idx;
  logic                      prox_found;
  logic                      ultimo_beat;

  // Zero padding past NUM_NA masks the missing lanes of a partial last beat.
  always_comb begin
    pad_ativo                                    = '0;
    pad_ativo[NUM_NA-1:0]                        = snap_ativo;
    pad_criterio                                 = '0;
    pad_criterio[NUM_NA*CRITERIO_WIDTH-1:0]      = snap_criterio;
  end

  always_comb begin
    base        = int'(beat) * LANES;
    lane_valido = LANES'(pad_ativo >> base);
    lane_valor  = LANE_BITS'(pad_criterio >> (base * CRITERIO_WIDTH));
    lane_indice = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_indice[l*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(base + l);
    end
  end

  arvore_menor #(
    .LANES          (LANES),
    .CRITERIO_WIDTH (CRITERIO_WIDTH),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_arvore (
    .valido       (lane_valido),
    .valor        (lane_valor),
    .indice       (lane_indice),
    .min_valor    (arv_valor),
    .min_indice   (arv_indice),
    .algum_valido (arv_valido)
  );

  // Strict less-than keeps the earlier beat's winner on ties across beats.
  always_comb begin
    toma        = arv_valido && (!found || (arv_valor < run_min));
    prox_min    = toma ? arv_valor  : run_min;
    prox_idx    = toma ? arv_indice : run_idx;
    prox_found  = found | arv_valido;
    ultimo_beat = (beat == LAST_BEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    if (start_in) begin
      estado_prox = SCAN;
    end else begin
      case (estado)
        SCAN:    if (ultimo_beat) estado_prox = DONE;
        default: estado_prox = estado;
      endcase
    end
  end

  always_comb begin
    ocupado_o = 1'b0;
    pronto_o  = 1'b0;
    case (estado)
      SCAN:    ocupado_o = 1'b1;
      DONE:    pronto_o  = 1'b1;
      default: ;
    endcase
  end

  // A start always wins over scan progress, so an aborted scan never publishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ativo    <= '0;
      snap_criterio <= '0;
      run_min       <= CRITERIO_MAX;
      run_idx       <= '0;
      found         <= 1'b0;
      beat          <= '0;
      criterio_o    <= CRITERIO_MAX;
      indice_o      <= '0;
      vazio_o       <= 1'b1;
    end else if (start_in) begin
      snap_ativo    <= na_ativo_in;
      snap_criterio <= na_criterio_in;
      run_min       <= CRITERIO_MAX;
      run_idx       <= '0;
      found         <= 1'b0;
      beat          <= '0;
    end else if (estado == SCAN) begin
      run_min <= prox_min;
      run_idx <= prox_idx;
      found   <= prox_found;
      beat    <= beat + 1'b1;
      if (ultimo_beat) begin
        criterio_o <= prox_found ? prox_min : CRITERIO_MAX;
        indice_o   <= prox_found ? prox_idx : '0;
        vazio_o    <= !prox_found;
      end
    end
  end

endmodule

// File: tb/tb_selecionar_menor_ativo.sv
// Scoreboard bench: stimulus pushes reference results, a negedge monitor pops and compares.
// A second group of NUM_NA=5 instances checks latency and indexing across lane counts.
module tb_selecionar_menor_ativo;

  localparam int NUM_NA = 8;
  localparam int CW     = 5;
  localparam int LANES  = 4;
  localparam int IW     = 3;
  localparam int BEATS  = (NUM_NA + LANES - 1) / LANES;

  typedef struct {
    logic [CW-1:0] criterio;
    logic [IW-1:0] indice;
    logic          vazio;
    int            ciclo;
  } esperado_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_in = 1'b0;
  logic [NUM_NA-1:0]    na_ativo_in = '0;
  logic [NUM_NA*CW-1:0] na_criterio_in = '0;
  logic                 ocupado_o, pronto_o, vazio_o;
  logic [CW-1:0]        criterio_o;
  logic [IW-1:0]        indice_o;

  logic        start5 = 1'b0;
  logic [4:0]  ativo5 = '0;
  logic [24:0] crit5_in = '0;
  logic        ocup5 [4];
  logic        pronto5 [4];
  logic        vaz5 [4];
  logic [4:0]  crit5 [4];
  logic [2:0]  idx5 [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_start = -100;
  logic tem = 1'b0;
  logic pronto_ant = 1'b0;
  esperado_t sb[$];
  esperado_t publicado;
  esperado_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  selecionar_menor_ativo #(
    .NUM_NA(NUM_NA), .CRITERIO_WIDTH(CW), .LANES(LANES)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in),
    .na_ativo_in(na_ativo_in), .na_criterio_in(na_criterio_in),
    .ocupado_o(ocupado_o), .pronto_o(pronto_o),
    .criterio_o(criterio_o), .indice_o(indice_o), .vazio_o(vazio_o)
  );

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 5;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    selecionar_menor_ativo #(
      .NUM_NA(5), .CRITERIO_WIDTH(5), .LANES(lanes_of(k))
    ) u_dut5 (
      .clk(clk), .rst_n(rst_n), .start_in(start5),
      .na_ativo_in(ativo5), .na_criterio_in(crit5_in),
      .ocupado_o(ocup5[k]), .pronto_o(pronto5[k]),
      .criterio_o(crit5[k]), .indice_o(idx5[k]), .vazio_o(vaz5[k])
    );
  end

  task automatic check_output(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nome, atual, esperado, cyc);
    end
  endtask

  // Reference: smallest criterio among active nodes, then the first node holding it.
  function automatic esperado_t modelo(input logic [NUM_NA-1:0] m, input logic [NUM_NA*CW-1:0] c);
    esperado_t e;
    int menor;
    menor = -1;
    for (int i = 0; i < NUM_NA; i++) begin
      if (m[i] && (menor < 0 || int'(c[i*CW +: CW]) < menor)) menor = int'(c[i*CW +: CW]);
    end
    e.vazio    = (menor < 0);
    e.criterio = e.vazio ? 5'h1F : CW'(menor);
    e.indice   = '0;
    e.ciclo    = 0;
    if (!e.vazio) begin
      for (int i = NUM_NA-1; i >= 0; i--) begin
        if (m[i] && int'(c[i*CW +: CW]) == menor) e.indice = IW'(i);
      end
    end
    return e;
  endfunction

  function automatic logic [NUM_NA*CW-1:0] rand_crit();
    logic [NUM_NA*CW-1:0] r;
    for (int i = 0; i < NUM_NA; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*CW +: CW] = 5'h1F;
        1:       r[i*CW +: CW] = CW'($urandom);
        default: r[i*CW +: CW] = CW'($urandom_range(0, 6));
      endcase
    end
    return r;
  endfunction

  function automatic logic [NUM_NA-1:0] rand_mask();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return NUM_NA'(1 << $urandom_range(0, NUM_NA-1));
      default: return NUM_NA'($urandom);
    endcase
  endfunction

  task automatic set_reset_model();
    publicado.criterio = 5'h1F;
    publicado.indice   = '0;
    publicado.vazio    = 1'b1;
    publicado.ciclo    = 0;
    sb.delete();
    tem        = 1'b0;
    last_start = -100;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      na_ativo_in    = rand_mask();
      na_criterio_in = rand_crit();
      @(posedge clk);
      #1;
    end
  endtask

  // A start sampled while the previous scan is still running replaces its pending result.
  task automatic apply_stimulus(input logic [NUM_NA-1:0] m, input logic [NUM_NA*CW-1:0] c);
    esperado_t e;
    int sc;
    sc             = cyc + 1;
    na_ativo_in    = m;
    na_criterio_in = c;
    start_in       = 1'b1;
    e              = modelo(m, c);
    e.ciclo        = sc + BEATS;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    if (tem && (sc - last_start <= BEATS) && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(e);
    last_start = sc;
    tem        = 1'b1;
  endtask

  always @(negedge clk) begin
    if (pronto_o && !pronto_ant) begin
      if (sb.size() == 0) begin
        check_output("unexpected_ready", 32'(pronto_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("latency", 32'(cyc), 32'(mon_e.ciclo));
        check_output("criterio", 32'(criterio_o), 32'(mon_e.criterio));
        check_output("indice", 32'(indice_o), 32'(mon_e.indice));
        check_output("vazio", 32'(vazio_o), 32'(mon_e.vazio));
        publicado = mon_e;
      end
    end else begin
      check_output("hold", 32'({criterio_o, indice_o, vazio_o}),
                   32'({publicado.criterio, publicado.indice, publicado.vazio}));
    end
    check_output("busy_ready", 32'({ocupado_o, pronto_o}),
                 32'({tem && cyc >= last_start && cyc < last_start + BEATS,
                      tem && cyc >= last_start + BEATS}));
    pronto_ant = pronto_o;
  end

  task automatic sweep(input logic [4:0] m, input logic [24:0] c, input logic [4:0] exp_crit, input logic exp_vazio);
    int lat [4];
    for (int k = 0; k < 4; k++) lat[k] = -1;
    ativo5   = m;
    crit5_in = c;
    start5   = 1'b1;
    @(posedge clk);
    #1;
    start5   = 1'b0;
    ativo5   = 5'($urandom);
    crit5_in = 25'($urandom);
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) begin
        if (pronto5[k] && lat[k] < 0) lat[k] = t;
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("sweep_latency_l%0d", lanes_of(k)), 32'(lat[k]), 32'((5 + lanes_of(k) - 1) / lanes_of(k)));
      check_output($sformatf("sweep_result_l%0d", lanes_of(k)), 32'({crit5[k], idx5[k], vaz5[k]}),
                   32'({exp_crit, 3'd4, exp_vazio}));
    end
  endtask

  initial begin
    set_reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", 32'({ocupado_o, pronto_o, criterio_o, indice_o, vazio_o}),
                 32'({1'b0, 1'b0, 5'h1F, 3'd0, 1'b1}));
    rst_n = 1'b1;
    idle_cycles(2);

    $display("[TB] directed cases");
    apply_stimulus(8'b1101_1110, {5'd8, 5'd5, 5'd1, 5'd12, 5'd3, 5'd9, 5'd3, 5'd7});
    idle_cycles(4);
    apply_stimulus(8'b1010_0000, {8{5'd4}});
    idle_cycles(4);
    apply_stimulus(8'h00, rand_crit());
    idle_cycles(4);
    apply_stimulus(8'h80, {5'h1F, 35'h0});
    idle_cycles(4);
    apply_stimulus(8'hFF, {5'd9, 5'd9, 5'd9, 5'd2, 5'd9, 5'd9, 5'd9, 5'd9});
    apply_stimulus(8'h0F, {5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd8, 5'd6, 5'd7});
    idle_cycles(4);
    apply_stimulus(8'b0110_0000, {5'd1, 5'd11, 5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0});
    idle_cycles(4);

    $display("[TB] reset during scan");
    apply_stimulus(8'hFF, rand_crit());
    set_reset_model();
    rst_n = 1'b0;
    #1;
    check_output("reset_midscan", 32'({ocupado_o, pronto_o, criterio_o, indice_o, vazio_o}),
                 32'({1'b0, 1'b0, 5'h1F, 3'd0, 1'b1}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(3);

    $display("[TB] random traffic");
    repeat (300) begin
      apply_stimulus(rand_mask(), rand_crit());
      idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(6);
    check_output("drain", 32'(sb.size()), 32'd0);

    $display("[TB] lane sweep NUM_NA=5");
    sweep(5'b11111, {5'd2, 5'd9, 5'd3, 5'd17, 5'd6}, 5'd2, 1'b0);
    sweep(5'b10000, {5'h1F, 5'd0, 5'd0, 5'd0, 5'd0}, 5'h1F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
